// File: rtl/cell_writer.sv
// Bump-pointer heap allocator: writes a Lisp cell (header + 1 or 2 payload words)
// into single-port RAM one word per cycle and returns the cell base or an OOM error.
module cell_writer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int TYPE_WIDTH = 3,
  parameter int HEAP_BASE  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [TYPE_WIDTH-1:0] req_type,
  input  logic                  req_nwords,
  input  logic [DATA_WIDTH-1:0] req_word0,
  input  logic [DATA_WIDTH-1:0] req_word1,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic                  resp_err,
  output logic [ADDR_WIDTH:0]   free_ptr
);
  localparam int PW = ADDR_WIDTH + 1;
  // One spare bit so free_ptr + 3 can never wrap in the fit check.
  localparam logic [PW:0] HEAP_END = {1'b0, 1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {IDLE, WR_HDR, WR_P0, WR_P1, RESP} state_e;

  state_e                  state_q, state_d;
  logic [TYPE_WIDTH-1:0]   type_q, type_d;
  logic                    nwords_q, nwords_d;
  logic [DATA_WIDTH-1:0]   w0_q, w0_d, w1_q, w1_d;
  logic [PW-1:0]           free_q, free_d;
  logic                    req_ready_q, req_ready_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    rvalid_q, rvalid_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic                    rerr_q, rerr_d;

  logic [PW:0]             need;
  logic                    fits;
  logic [ADDR_WIDTH-1:0]   base;

  assign base = free_q[ADDR_WIDTH-1:0];
  assign need = {1'b0, free_q} + (PW+1)'(2) + {{PW{1'b0}}, req_nwords};
  assign fits = (need <= HEAP_END);

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    nwords_d    = nwords_q;
    w0_d        = w0_q;
    w1_d        = w1_q;
    free_d      = free_q;
    req_ready_d = req_ready_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rvalid_d    = rvalid_q;
    raddr_d     = raddr_q;
    rerr_d      = rerr_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          type_d      = req_type;
          nwords_d    = req_nwords;
          w0_d        = req_word0;
          w1_d        = req_word1;
          req_ready_d = 1'b0;
          if (fits) begin
            state_d = WR_HDR;
            we_d    = 1'b1;
            addr_d  = base;
            // Header: mark bit clear, type tag zero-extended.
            wdata_d = {{(DATA_WIDTH-TYPE_WIDTH-1){1'b0}}, 1'b0, req_type};
          end else begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            raddr_d  = '0;
            rerr_d   = 1'b1;
          end
        end
      end
      WR_HDR: begin
        state_d = WR_P0;
        we_d    = 1'b1;
        addr_d  = base + ADDR_WIDTH'(1);
        wdata_d = w0_q;
      end
      WR_P0: begin
        if (nwords_q) begin
          state_d = WR_P1;
          we_d    = 1'b1;
          addr_d  = base + ADDR_WIDTH'(2);
          wdata_d = w1_q;
        end else begin
          state_d  = RESP;
          free_d   = free_q + PW'(2);
          rvalid_d = 1'b1;
          raddr_d  = base;
          rerr_d   = 1'b0;
        end
      end
      WR_P1: begin
        state_d  = RESP;
        free_d   = free_q + PW'(3);
        rvalid_d = 1'b1;
        raddr_d  = base;
        rerr_d   = 1'b0;
      end
      RESP: begin
        if (resp_ready) begin
          state_d     = IDLE;
          rvalid_d    = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      type_q      <= '0;
      nwords_q    <= 1'b0;
      w0_q        <= '0;
      w1_q        <= '0;
      free_q      <= PW'(HEAP_BASE);
      req_ready_q <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rvalid_q    <= 1'b0;
      raddr_q     <= '0;
      rerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      nwords_q    <= nwords_d;
      w0_q        <= w0_d;
      w1_q        <= w1_d;
      free_q      <= free_d;
      req_ready_q <= req_ready_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rvalid_q    <= rvalid_d;
      raddr_q     <= raddr_d;
      rerr_q      <= rerr_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign resp_valid = rvalid_q;
  assign resp_addr  = raddr_q;
  assign resp_err   = rerr_q;
  assign free_ptr   = free_q;
endmodule

// File: doc/cell_writer.md
Name: cell_writer

Overview:
- Write-side companion to the synchronous cell ROM.
- Allocates Lisp cells in heap RAM by bump pointer and writes each one as a header word followed by 1 or 2 payload words.
- Accepts allocation requests over a valid/ready handshake, drives a single-port RAM write interface (one word per cycle), and returns the cell's base address or an out-of-memory error.
- Cell layout matches ROM images: header = zero-extended {mark=1'b0, type}, payload at base+1 (and base+2).

Parameters:
- ADDR_WIDTH, 10, RAM word address width; heap ends at 2^ADDR_WIDTH.
- DATA_WIDTH, 16, RAM word width.
- TYPE_WIDTH, 3, width of the lisp type tag.
- HEAP_BASE, 2, first allocatable address; words below it hold ROM-loaded constants.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  allocation request present
- req_ready  output  1  block can accept a request
- req_type  input  TYPE_WIDTH  cell type tag
- req_nwords  input  1  0 = one payload word (number), 1 = two payload words (cons)
- req_word0  input  DATA_WIDTH  first payload word
- req_word1  input  DATA_WIDTH  second payload word, ignored when req_nwords=0
- mem_we  output  1  RAM write strobe
- mem_addr  output  ADDR_WIDTH  RAM write address
- mem_wdata  output  DATA_WIDTH  RAM write data
- resp_valid  output  1  allocation result available
- resp_ready  input  1  consumer takes result
- resp_addr  output  ADDR_WIDTH  base address of written cell, 0 on error
- resp_err  output  1  out of memory, nothing written
- free_ptr  output  ADDR_WIDTH+1  next free address

Behaviour:
- Reset (asynchronous, any state): state=IDLE; req_ready=1; mem_we=0; mem_addr=0; mem_wdata=0; resp_valid=0; resp_addr=0; resp_err=0; free_ptr=HEAP_BASE.
- States: IDLE, WR_HDR, WR_P0, WR_P1, RESP.
- IDLE:
  - req_ready=1.
  - Handshake when req_valid&&req_ready on edge N: latch type, nwords and both words.
  - Fit check in ADDR_WIDTH+1 bits: free_ptr + 2 + nwords <= 2^ADDR_WIDTH.
  - Fits -> WR_HDR. Does not fit -> RESP with resp_err=1, resp_addr=0, free_ptr unchanged.
- WR_HDR: mem_we=1, mem_addr=free_ptr, mem_wdata={zeros, 1'b0, type} -> WR_P0.
- WR_P0: mem_we=1, mem_addr=free_ptr+1, mem_wdata=word0.
  - nwords=1 -> WR_P1.
  - nwords=0 -> RESP; free_ptr += 2 on this edge.
- WR_P1: mem_we=1, mem_addr=free_ptr+2, mem_wdata=word1 -> RESP; free_ptr += 3 on this edge.
- RESP:
  - resp_valid=1, resp_addr=cell base (pre-increment free_ptr), resp_err as decided.
  - Outputs held stable until resp_valid&&resp_ready, then -> IDLE.
  - req_ready=0 in every state except IDLE.
- Output timing: all outputs registered.
  - Handshake at edge N: header write visible cycle N+1, payload N+2 (and N+3).
  - resp_valid rises N+3 (number) or N+4 (cons).
  - Error: resp_valid rises N+1, and mem_we never asserts.
- mem_we deasserts in IDLE and RESP; mem_addr/mem_wdata hold their last value when mem_we=0.
- free_ptr is monotonic (no GC in this block); it may equal exactly 2^ADDR_WIDTH, after which every request errors.
- A request is never dropped; back-to-back requests are accepted one cycle after the response handshake (IDLE re-entered).
- Reset mid-write aborts; partially written words stay in RAM but free_ptr returns to HEAP_BASE, so the space is reused.

Test Plan:
- Reset then number request type=1, word0=16'h2A2A -> writes addr2=0x0001, addr3=0x2A2A on consecutive cycles; resp_addr=2, resp_err=0, free_ptr=4, resp_valid 3 cycles after handshake.
- Cons request type=2, word0=0x0002, word1=0x0000 after the above -> writes addr4=0x0002, addr5=0x0002, addr6=0x0000; resp_addr=4; free_ptr=7.
- ADDR_WIDTH=3, HEAP_BASE=2, two cons requests -> first at 2 (free_ptr=5), second at 5 (free_ptr=8 exactly full); third number request -> resp_err=1, resp_addr=0, no mem_we pulses, free_ptr stays 8.
- Hold resp_ready=0 for 5 cycles -> resp_valid, resp_addr, resp_err stable; req_ready=0; a waiting req_valid is not accepted until 1 cycle after resp_ready=1.
- Assert rst during WR_P0 of a cons request -> mem_we drops immediately; state IDLE, free_ptr=HEAP_BASE; next number request returns resp_addr=HEAP_BASE.
- Back-to-back req_valid held high with 10 number requests and resp_ready=1 -> addresses 2,4,...,20, with exactly one mem_we pulse per word and none overlapping.
